mac_sched_ctrl: RTL and testbench
=================================

MAC_SCHED_CTRL -- requirements
Module: mac_sched_ctrl

Interface
REQ-001 SHALL have parameter N_MACS, default 4: number of MAC columns driven.
REQ-002 SHALL have parameter VC_W, default 12: width of the valid_ctrl wavefront.
REQ-003 SHALL have parameter CNT_W, default 8: width of the job length fields.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port req, input, 2 bits: job request, level. Bit 0 is the pipeline requester; bit 1 is the layering requester.
REQ-007 SHALL have port len_0, input, CNT_W bits: activation beat count for requester 0.
REQ-008 SHALL have port len_1, input, CNT_W bits: activation beat count for requester 1.
REQ-009 SHALL have port abort, input, 1 bit: terminate the current job.
REQ-010 SHALL have port gnt, output, 2 bits: one-hot owner of the MAC array.
REQ-011 SHALL have port done, output, 2 bits: one-cycle completion pulse, indexed by requester.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-013 SHALL have port mode, output, 3 bits: 0 = idle, 1 = pipeline, 2 = layering.
REQ-014 SHALL have port load_weights, output, 1 bit: weight load strobe.
REQ-015 SHALL have port clear, output, N_MACS bits: accumulator clear.
REQ-016 SHALL have port a_rd_en, output, 1 bit: activation fetch enable.
REQ-017 SHALL have port valid_ctrl, output, VC_W bits: valid wavefront for the MAC array.

Function
REQ-018 SHALL register every output; no output is a combinational function of the inputs.
REQ-019 SHALL implement the states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-020 In IDLE with req != 0, SHALL grant on that edge and enter LOAD, latching the owner's len into the beat counter.
REQ-021 SHALL arbitrate round-robin: when both requests are set, the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-022 In LOAD (exactly 1 cycle), SHALL drive load_weights=1 and clear set to all ones; the next state is STREAM if len != 0, else DONE.
REQ-023 In STREAM (exactly len cycles), SHALL drive a_rd_en=1.
REQ-024 SHALL update valid_ctrl every cycle as {valid_ctrl[VC_W-2:0], s}, where s=1 for a cycle whose state is STREAM and s=0 otherwise; the first STREAM cycle shows 0x001.
REQ-025 In DRAIN (exactly VC_W-1 cycles), SHALL drive a_rd_en=0 and keep shifting; valid_ctrl is 0 in DONE.
REQ-026 In DONE (1 cycle), SHALL drive done[owner]=1, then return to IDLE.
REQ-027 SHALL hold gnt and mode constant from LOAD through DONE; both are 0 in IDLE.
REQ-028 SHALL have busy=1 in LOAD, STREAM, DRAIN and DONE.
REQ-029 SHALL sample req only in IDLE; req changes while busy are ignored.
REQ-030 A requester holding req after done SHALL be re-arbitrated; there is a minimum of 1 IDLE cycle between jobs.
REQ-031 SHALL capture len only at grant; later changes to len_0 or len_1 have no effect on the current job.
REQ-032 For len = 2^CNT_W-1 (255), the beat counter SHALL not wrap; STREAM lasts exactly 255 cycles.
REQ-033 With abort=1 in any non-IDLE state, the next cycle SHALL be IDLE with valid_ctrl=0, a_rd_en=0 and clear set to all ones for 1 cycle.
REQ-034 On abort, done SHALL not pulse and the round-robin pointer SHALL still advance.
REQ-035 abort in IDLE SHALL be ignored; abort and req together in IDLE SHALL grant normally.

Reset
REQ-036 When rst=0 at a clock edge, SHALL go to IDLE with gnt=0, done=0, busy=0, mode=0, load_weights=0, clear=0, a_rd_en=0, valid_ctrl=0 and the round-robin pointer = 1.
REQ-037 Reset during any state, including mid-STREAM, SHALL take precedence over abort and req; no done pulse is produced.

Structure
REQ-038 SHALL place the state encoding and the mode encodings (MODE_IDLE=0, MODE_PIPE=1, MODE_LAYER=2) in the shared package mac_sched_pkg.
REQ-039 SHALL implement the 2-requester round-robin grant logic as the sub-module rr_arbiter, with inputs req and ptr and a one-hot gnt output.

Verification
REQ-040 SHALL cover: req=01, len_0=3 -> LOAD 1 cycle with clear=4'hF; STREAM 3 cycles with valid_ctrl 0x001, 0x003, 0x007; DRAIN 11 cycles ending at 0x800; done=01 on busy cycle 16; mode=1 throughout.
REQ-041 SHALL cover: req=11 held continuously, len_0=len_1=2 after reset -> grants alternate 01, 10, 01, with exactly 1 IDLE cycle between jobs.
REQ-042 SHALL cover: req=10, len_1=0 -> LOAD then DONE; busy for 2 cycles; a_rd_en never 1; done=10.
REQ-043 SHALL cover: abort on the 2nd STREAM cycle of a len=5 job -> next cycle IDLE, valid_ctrl=0, clear=4'hF for 1 cycle, no done pulse; the next tie grants the other requester.
REQ-044 SHALL cover: rst=0 mid-DRAIN -> all outputs at reset values on the following cycle; a following req=01, len_0=1 runs a normal 1-beat job.
REQ-045 SHALL cover: len_0=255 -> exactly 255 a_rd_en cycles, with no counter wrap.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MAC array scheduler.
//   state_e    : scheduler FSM states
//   MODE_*     : encodings presented on the mode output
//   mode_of()  : maps a one-hot owner to its mode encoding
package mac_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_PIPE  = 3'd1;
  localparam logic [2:0] MODE_LAYER = 3'd2;

  // Requester 0 is the pipeline client, requester 1 the layering client.
  function automatic logic [2:0] mode_of(input logic [1:0] owner);
    if (owner[1]) return MODE_LAYER;
    if (owner[0]) return MODE_PIPE;
    return MODE_IDLE;
  endfunction

endpackage

// File: rtl/mac_sched_ctrl_if.sv
// Request/response bundle between the job requesters and the MAC scheduler.
//   req[1:0]            job request level (bit 0 pipeline, bit 1 layering)
//   len_0 / len_1       activation beat counts per requester
//   abort               terminate the running job
//   gnt, done, busy     ownership, completion pulse, activity
//   mode                0 idle, 1 pipeline, 2 layering
//   load_weights, clear, a_rd_en, valid_ctrl   MAC array controls
// slave  : scheduler side, master : requester side.
interface mac_sched_ctrl_if #(
  parameter int N_MACS = 4,
  parameter int VC_W   = 12,
  parameter int CNT_W  = 8
);
  logic [1:0]        req;
  logic [CNT_W-1:0]  len_0;
  logic [CNT_W-1:0]  len_1;
  logic              abort;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic [2:0]        mode;
  logic              load_weights;
  logic [N_MACS-1:0] clear;
  logic              a_rd_en;
  logic [VC_W-1:0]   valid_ctrl;

  modport master (
    output req, len_0, len_1, abort,
    input  gnt, done, busy, mode, load_weights, clear, a_rd_en, valid_ctrl
  );

  modport slave (
    input  req, len_0, len_1, abort,
    output gnt, done, busy, mode, load_weights, clear, a_rd_en, valid_ctrl
  );
endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant.
//   req[1:0] : request vector
//   ptr      : index of the requester granted last
//   gnt[1:0] : one-hot grant (all zero when nothing requests)
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      // A requester wins when it asks alone, or on a tie when it did not win last.
      assign gnt[gi] = req[gi] && (!req[1-gi] || (ptr != 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/mac_sched_ctrl.sv
// Job scheduler for a column of MAC units.
// One job at a time: grant -> LOAD (weights, clear) -> STREAM (len beats of
// activation fetch) -> DRAIN (flush the valid wavefront) -> DONE (pulse).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : mac_sched_ctrl_if.slave request/response bundle
// All outputs come straight from flops; each is computed from the next state.
module mac_sched_ctrl
  import mac_sched_pkg::*;
#(
  parameter int N_MACS = 4,
  parameter int VC_W   = 12,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_sched_ctrl_if.slave  bus
);

  localparam int DR_W = (VC_W > 2) ? $clog2(VC_W) : 1;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DR_W-1:0]   drn_q, drn_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic [2:0]        mode_q, mode_d;
  logic              lw_q, lw_d;
  logic [N_MACS-1:0] clear_q, clear_d;
  logic              rd_q, rd_d;
  logic [VC_W-1:0]   vc_q, vc_d;

  logic [1:0]        arb_gnt;
  logic              aborting;
  logic              clear_all;

  rr_arbiter u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    drn_d     = drn_q;
    gnt_d     = gnt_q;
    mode_d    = mode_q;
    clear_all = 1'b0;
    aborting  = (state_q != ST_IDLE) && bus.abort;

    if (aborting) begin
      // Drop the job immediately and wipe the accumulators; the pointer
      // already moved at grant time so the other requester wins the next tie.
      state_d   = ST_IDLE;
      gnt_d     = 2'b00;
      mode_d    = MODE_IDLE;
      clear_all = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            state_d = ST_LOAD;
            gnt_d   = arb_gnt;
            mode_d  = mode_of(arb_gnt);
            ptr_d   = arb_gnt[1];
            cnt_d   = arb_gnt[1] ? bus.len_1 : bus.len_0;
          end
        end
        ST_LOAD: begin
          state_d = (cnt_q != '0) ? ST_STREAM : ST_DONE;
        end
        ST_STREAM: begin
          // cnt_q holds the beats still to go, including this one.
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DRAIN;
            drn_d   = DR_W'(VC_W - 1);
          end
        end
        ST_DRAIN: begin
          drn_d = drn_q - DR_W'(1);
          if (drn_q == DR_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          mode_d  = MODE_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          mode_d  = MODE_IDLE;
        end
      endcase
    end

    if (state_d == ST_LOAD) begin
      clear_all = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
    lw_d   = (state_d == ST_LOAD);
    rd_d   = (state_d == ST_STREAM);
    done_d = (state_d == ST_DONE) ? gnt_q : 2'b00;

    // The wavefront injects a one for every STREAM cycle; it is empty by
    // construction in DONE, and forced empty in IDLE so an abort flushes it.
    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      vc_d = '0;
    end else begin
      vc_d = {vc_q[VC_W-2:0], (state_d == ST_STREAM)};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_MACS; gi++) begin : g_clear
      assign clear_d[gi] = clear_all;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      drn_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      mode_q  <= MODE_IDLE;
      lw_q    <= 1'b0;
      clear_q <= '0;
      rd_q    <= 1'b0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      lw_q    <= lw_d;
      clear_q <= clear_d;
      rd_q    <= rd_d;
      vc_q    <= vc_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.mode         = mode_q;
  assign bus.load_weights = lw_q;
  assign bus.clear        = clear_q;
  assign bus.a_rd_en      = rd_q;
  assign bus.valid_ctrl   = vc_q;

endmodule

// File: tb/tb_mac_sched_ctrl.sv
// Scoreboard bench for mac_sched_ctrl: the stimulus process pushes the
// hand-computed summary of each job; the monitor rebuilds the observed summary
// from the outputs and compares when the job ends (busy falls).
module tb_mac_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_sched_ctrl_if #(.N_MACS(4), .VC_W(12), .CNT_W(8)) bus ();

  mac_sched_ctrl #(.N_MACS(4), .VC_W(12), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic [2:0]  mode;
    int          busy;
    int          rd;
    int          lw;
    logic [3:0]  clr_load;
    logic [1:0]  done_val;
    int          done_at;
    int          done_cyc;
    logic [11:0] vc2;
    logic [11:0] vc3;
    logic [11:0] vc4;
    logic [11:0] vc_pen;
    logic [11:0] vc_fin;
    logic [3:0]  post_clear;
    logic [11:0] post_vc;
    logic        post_rd;
    int          gap;
  } job_t;

  job_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic job_t blank_job();
    job_t j;
    j.gnt = 2'b00; j.mode = 3'd0; j.busy = 0; j.rd = 0; j.lw = 0;
    j.clr_load = 4'h0; j.done_val = 2'b00; j.done_at = 0; j.done_cyc = 0;
    j.vc2 = 12'h0; j.vc3 = 12'h0; j.vc4 = 12'h0; j.vc_pen = 12'h0; j.vc_fin = 12'h0;
    j.post_clear = 4'h0; j.post_vc = 12'h0; j.post_rd = 1'b0; j.gap = -1;
    return j;
  endfunction

  function automatic job_t mk_job(input logic [1:0] g, input logic [2:0] m, input int busy,
                                  input int rd, input logic [1:0] dv, input int dat,
                                  input logic [11:0] v2, input logic [11:0] v3,
                                  input logic [11:0] v4, input logic [11:0] vp,
                                  input logic [11:0] vf, input logic [3:0] pc, input int gap);
    job_t j;
    j = blank_job();
    j.gnt = g; j.mode = m; j.busy = busy; j.rd = rd; j.lw = 1; j.clr_load = 4'hF;
    j.done_val = dv; j.done_at = dat; j.done_cyc = (dv != 2'b00) ? 1 : 0;
    j.vc2 = v2; j.vc3 = v3; j.vc4 = v4; j.vc_pen = vp; j.vc_fin = vf;
    j.post_clear = pc; j.gap = gap;
    return j;
  endfunction

  // ---------------- monitor ----------------
  job_t        obs;
  int          in_job = 0;
  int          cnt = 0;
  int          idle_cnt = 0;
  int          stray = 0;
  int          jobs = 0;
  logic        gstable = 1'b1;
  logic [11:0] vc_prev = 12'h0;
  logic [11:0] vc_cur = 12'h0;

  task automatic finish_job();
    job_t e;
    jobs++;
    $display("[TB] job %0d: gnt=%b mode=%0d busy=%0d rd=%0d done=%b@%0d clear_after=%h gap=%0d",
             jobs, obs.gnt, obs.mode, obs.busy, obs.rd, obs.done_val, obs.done_at,
             obs.post_clear, obs.gap);
    if (exp_q.size() == 0) begin
      chk("job_unexpected", 32'(jobs), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk("gnt", 32'(obs.gnt), 32'(e.gnt));
      chk("mode", 32'(obs.mode), 32'(e.mode));
      chk("gnt_mode_stable", 32'(gstable), 32'(1));
      chk("busy_cycles", obs.busy, e.busy);
      chk("a_rd_en_cycles", obs.rd, e.rd);
      chk("load_weights_cycles", obs.lw, e.lw);
      chk("clear_in_load", 32'(obs.clr_load), 32'(e.clr_load));
      chk("done_value", 32'(obs.done_val), 32'(e.done_val));
      chk("done_cycle", obs.done_at, e.done_at);
      chk("done_width", obs.done_cyc, e.done_cyc);
      chk("vc_cycle2", 32'(obs.vc2), 32'(e.vc2));
      chk("vc_cycle3", 32'(obs.vc3), 32'(e.vc3));
      chk("vc_cycle4", 32'(obs.vc4), 32'(e.vc4));
      chk("vc_penultimate", 32'(obs.vc_pen), 32'(e.vc_pen));
      chk("vc_final", 32'(obs.vc_fin), 32'(e.vc_fin));
      chk("clear_after_job", 32'(obs.post_clear), 32'(e.post_clear));
      chk("vc_after_job", 32'(obs.post_vc), 32'(e.post_vc));
      chk("a_rd_en_after_job", 32'(obs.post_rd), 32'(e.post_rd));
      chk("done_outside_job", stray, 0);
      if (e.gap >= 0) chk("idle_gap", obs.gap, e.gap);
    end
    stray = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (in_job == 0) begin
          in_job  = 1;
          cnt     = 0;
          obs     = blank_job();
          obs.gnt = bus.gnt;
          obs.mode = bus.mode;
          obs.gap = idle_cnt;
          gstable = 1'b1;
          vc_prev = 12'h0;
          vc_cur  = 12'h0;
        end
        cnt++;
        if (bus.gnt !== obs.gnt || bus.mode !== obs.mode) gstable = 1'b0;
        if (bus.a_rd_en === 1'b1) obs.rd++;
        if (bus.load_weights === 1'b1) obs.lw++;
        if (cnt == 1) obs.clr_load = bus.clear;
        if (bus.done !== 2'b00) begin
          obs.done_val = obs.done_val | bus.done;
          obs.done_at  = cnt;
          obs.done_cyc++;
        end
        if (cnt == 2) obs.vc2 = bus.valid_ctrl;
        if (cnt == 3) obs.vc3 = bus.valid_ctrl;
        if (cnt == 4) obs.vc4 = bus.valid_ctrl;
        vc_prev = vc_cur;
        vc_cur  = bus.valid_ctrl;
      end else begin
        if (bus.done !== 2'b00) stray++;
        if (in_job != 0) begin
          in_job         = 0;
          obs.busy       = cnt;
          obs.vc_pen     = vc_prev;
          obs.vc_fin     = vc_cur;
          obs.post_clear = bus.clear;
          obs.post_vc    = bus.valid_ctrl;
          obs.post_rd    = bus.a_rd_en;
          finish_job();
          idle_cnt = 1;
        end else begin
          idle_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: busy stayed at 0x%0h, expected 0x%0h within %0d cycles",
               name, bus.busy, lvl, budget);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_mode"}, 32'(bus.mode), 32'(0));
    chk({tag, "_load_weights"}, 32'(bus.load_weights), 32'(0));
    chk({tag, "_clear"}, 32'(bus.clear), 32'(0));
    chk({tag, "_a_rd_en"}, 32'(bus.a_rd_en), 32'(0));
    chk({tag, "_valid_ctrl"}, 32'(bus.valid_ctrl), 32'(0));
  endtask

  initial begin
    bus.req   = 2'b00;
    bus.len_0 = 8'd0;
    bus.len_1 = 8'd0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    repeat (3) step();
    reset_checks("por");
    rst = 1'b1;
    step();

    // A: pipeline job, len 3; len_0 changed after grant must not matter.
    exp_q.push_back(mk_job(2'b01, 3'd1, 16, 3, 2'b01, 16,
                           12'h001, 12'h003, 12'h007, 12'h800, 12'h000, 4'h0, -1));
    bus.len_0 = 8'd3;
    bus.req   = 2'b01;
    wait_busy(1'b1, 20, "A_start");
    bus.req   = 2'b00;
    bus.len_0 = 8'd7;
    wait_busy(1'b0, 50, "A_end");
    step(); step();

    // B: layering job with len 0 goes LOAD -> DONE.
    exp_q.push_back(mk_job(2'b10, 3'd2, 2, 0, 2'b10, 2,
                           12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 4'h0, -1));
    bus.len_1 = 8'd0;
    bus.req   = 2'b10;
    wait_busy(1'b1, 20, "B_start");
    bus.req   = 2'b00;
    wait_busy(1'b0, 20, "B_end");
    step(); step();

    // C: continuous tie after reset alternates 01, 10, 01 with one idle cycle between.
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    exp_q.push_back(mk_job(2'b01, 3'd1, 15, 2, 2'b01, 15,
                           12'h001, 12'h003, 12'h006, 12'h800, 12'h000, 4'h0, -1));
    exp_q.push_back(mk_job(2'b10, 3'd2, 15, 2, 2'b10, 15,
                           12'h001, 12'h003, 12'h006, 12'h800, 12'h000, 4'h0, 1));
    exp_q.push_back(mk_job(2'b01, 3'd1, 15, 2, 2'b01, 15,
                           12'h001, 12'h003, 12'h006, 12'h800, 12'h000, 4'h0, 1));
    bus.len_0 = 8'd2;
    bus.len_1 = 8'd2;
    bus.req   = 2'b11;
    wait_busy(1'b1, 20, "C1_start");
    wait_busy(1'b0, 50, "C1_end");
    wait_busy(1'b1, 20, "C2_start");
    wait_busy(1'b0, 50, "C2_end");
    wait_busy(1'b1, 20, "C3_start");
    bus.req = 2'b00;
    wait_busy(1'b0, 50, "C3_end");
    step(); step();

    // D: tie grants requester 1 (last was 0); abort on its 2nd STREAM cycle,
    // then the held tie goes to requester 0 after exactly one idle cycle.
    exp_q.push_back(mk_job(2'b10, 3'd2, 3, 2, 2'b00, 0,
                           12'h001, 12'h003, 12'h000, 12'h001, 12'h003, 4'hF, -1));
    exp_q.push_back(mk_job(2'b01, 3'd1, 14, 1, 2'b01, 14,
                           12'h001, 12'h002, 12'h004, 12'h800, 12'h000, 4'h0, 1));
    bus.len_0 = 8'd1;
    bus.len_1 = 8'd5;
    bus.req   = 2'b11;
    wait_busy(1'b1, 20, "D1_start");
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_clear", 32'(bus.clear), 32'(4'hF));
    chk("abort_valid_ctrl", 32'(bus.valid_ctrl), 32'(0));
    chk("abort_a_rd_en", 32'(bus.a_rd_en), 32'(0));
    chk("abort_gnt", 32'(bus.gnt), 32'(0));
    wait_busy(1'b1, 20, "D2_start");
    bus.req = 2'b00;
    wait_busy(1'b0, 50, "D2_end");
    step(); step();

    // E: reset in the 3rd DRAIN cycle, together with abort and req, wins over both.
    exp_q.push_back(mk_job(2'b01, 3'd1, 6, 2, 2'b00, 0,
                           12'h001, 12'h003, 12'h006, 12'h00C, 12'h018, 4'h0, -1));
    bus.len_0 = 8'd2;
    bus.req   = 2'b01;
    wait_busy(1'b1, 20, "E1_start");
    bus.req = 2'b00;
    repeat (5) step();
    rst       = 1'b0;
    bus.abort = 1'b1;
    bus.req   = 2'b01;
    step();
    reset_checks("midrst");
    rst       = 1'b1;
    bus.abort = 1'b0;
    exp_q.push_back(mk_job(2'b01, 3'd1, 14, 1, 2'b01, 14,
                           12'h001, 12'h002, 12'h004, 12'h800, 12'h000, 4'h0, -1));
    bus.len_0 = 8'd1;
    wait_busy(1'b1, 20, "E2_start");
    bus.req = 2'b00;
    wait_busy(1'b0, 50, "E2_end");
    step(); step();

    // F: longest job, granted while abort is raised in IDLE (ignored there).
    exp_q.push_back(mk_job(2'b01, 3'd1, 268, 255, 2'b01, 268,
                           12'h001, 12'h003, 12'h007, 12'h800, 12'h000, 4'h0, -1));
    bus.len_0 = 8'd255;
    bus.abort = 1'b1;
    bus.req   = 2'b01;
    wait_busy(1'b1, 20, "F_start");
    bus.abort = 1'b0;
    bus.req   = 2'b00;
    wait_busy(1'b0, 400, "F_end");
    step(); step(); step();

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
